// File: rtl/fetch_queue_if.sv
// Fetch-side bundle: instruction memory request/response, redirect, and the DOF handshake.
// master = fetch_queue, slave = memory/decode environment.
interface fetch_queue_if #(
    parameter int ADDR_W = 14
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic [31:0]       imem_rdata;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              ir_valid;
    logic              ir_ready;
    logic [31:0]       ir;
    logic [31:0]       ir_pc_1;

    modport master (
        output imem_req, imem_addr, ir_valid, ir, ir_pc_1,
        input  imem_gnt, imem_rdata, redirect, redirect_pc, ir_ready
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, ir, ir_pc_1,
        output imem_gnt, imem_rdata, redirect, redirect_pc, ir_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: grant-to-ir_valid is 2 cycles; requests are credit-limited
// so queued + in-flight never exceeds DEPTH, and a redirect flushes everything in one cycle.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 14
) (
    input logic           clk,
    input logic           reset,
    fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t            queue [DEPTH];
    entry_t            head;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              inflight;
    logic              drop;
    logic              req;
    logic              grant;
    logic              push;
    logic              pop;
    logic              valid;

    // The in-flight word holds a credit, so count + inflight never exceeds DEPTH.
    assign req   = !reset && !bus.redirect &&
                   ((count + CNT_W'(inflight)) < CNT_W'(DEPTH));
    assign grant = req && bus.imem_gnt;
    assign valid = !reset && (count != '0);
    assign pop   = valid && bus.ir_ready && !bus.redirect;
    assign push  = inflight && !drop && !bus.redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= '0;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            drop        <= 1'b0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc[ADDR_W-1:0];
            inflight <= 1'b0;
            // A word granted before the redirect belongs to the old stream.
            drop     <= inflight;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (grant) begin
                fetch_pc    <= fetch_pc + ADDR_W'(1);
                inflight_pc <= fetch_pc;
            end
            inflight <= grant;
            drop     <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: outputs are gated by valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            queue[wr_ptr] <= '{instr: bus.imem_rdata, pc: inflight_pc};
        end
    end

    assign head          = queue[rd_ptr];
    assign bus.imem_req  = req;
    assign bus.imem_addr = reset ? '0 : fetch_pc;
    assign bus.ir_valid  = valid;
    assign bus.ir        = valid ? head.instr : 32'd0;
    assign bus.ir_pc_1   = valid ? (32'(head.pc) + 32'd1) : 32'd0;
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end for the pipelined RISC CPU. It issues word requests to instruction memory, buffers up to DEPTH returned instructions with their PC+1, and presents them to the DOF stage through a valid/ready handshake. A taken branch or jump redirects fetch and flushes the queue. It replaces the bare PC/IR registers of the IF stage and decouples fetch from decode stalls.

## Interface
- DEPTH, 4: queue entries; a power of two, at least 2.
- ADDR_W, 14: instruction memory word-address width.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  request valid; imem_addr is meaningful while high.
- imem_addr  out  ADDR_W  word address being fetched.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rdata  in  32  instruction word, valid exactly 1 cycle after a granted request.
- redirect  in  1  branch/jump taken (EX mux_C select ≠ 0); flush and refetch.
- redirect_pc  in  32  new fetch address; bits [ADDR_W-1:0] are used.
- ir_valid  out  1  ir/ir_pc_1 hold a valid instruction.
- ir_ready  in  1  DOF accepts the instruction this cycle.
- ir  out  32  instruction word (head of the queue).
- ir_pc_1  out  32  address of this instruction + 1, zero-extended 32-bit add.

## Operation
- State: fetch_pc (ADDR_W), circular queue of DEPTH × {instr[31:0], pc[ADDR_W-1:0]}, wr_ptr/rd_ptr (log2 DEPTH), count (0..DEPTH), inflight (0/1), drop (0/1).
- Issue: imem_req = !reset && !redirect && (count + inflight < DEPTH). imem_addr = fetch_pc.
- On imem_req && imem_gnt: fetch_pc += 1 (wraps 2^ADDR_W−1 → 0); set inflight for the next cycle; record the issued address for the returning entry.
- Return: in the cycle after a grant, if drop is 0, push {imem_rdata, issued pc} at wr_ptr. If drop is 1, discard the word.
- Pop: ir_valid && ir_ready advances rd_ptr. Push and pop may occur in the same cycle; count is unchanged in that case.
- Credit rule guarantees no overflow: a push never occurs with count == DEPTH.
- Redirect has priority over everything in its cycle:
  - count, wr_ptr, and rd_ptr are cleared.
  - fetch_pc is loaded with redirect_pc[ADDR_W-1:0].
  - A simultaneous pop or push is ignored.
  - If a grant occurred in the previous cycle, its response is dropped (drop set for one cycle).
  - imem_req is 0 during the redirect cycle.
- Back-to-back redirects: the last one wins; each one flushes.
- ir/ir_pc_1 are driven from the head entry. Their value is don't-care when ir_valid = 0, but they must be driven as 0 after reset.

## Timing
- Reset values:
  - imem_req = 0, imem_addr = 0, ir_valid = 0, ir = 0, ir_pc_1 = 0.
  - fetch_pc = 0, count = 0, inflight = 0, drop = 0.
- Reset mid-operation discards everything, including any in-flight response.
- Cycle 0 after reset deasserts: imem_req = 1, addr 0.
- Latency with grant at cycle n: data returns at n+1, is pushed at the end of n+1, and ir_valid = 1 at n+2. Minimum is 2 cycles from grant to ir_valid.
- Throughput with imem_gnt held high and ir_ready high: one instruction per cycle, no bubbles after fill.
- With ir_ready low: requests stop once count + inflight reaches DEPTH. Exactly DEPTH entries are buffered and none are lost.
- Redirect at cycle r: imem_req = 1 with addr = redirect_pc at r+1, and the first redirected ir_valid at r+3 (given a grant at r+1). ir_valid = 0 during cycles r+1 through r+2.
- Without a grant, imem_req/imem_addr hold stable.

## Test plan
- Reset then free run (gnt = 1, ready = 1), memory word[i] = 0x1000_0000 + i: ir_valid first at cycle 2 with ir = 0x1000_0000 and ir_pc_1 = 1. Each following cycle delivers i+1 in order.
- Hold ir_ready = 0 from cycle 0: exactly 4 requests are granted (addresses 0–3) and imem_req then stays 0. Releasing ready pops 0,1,2,3 on consecutive cycles and fetching resumes at address 4.
- Redirect to 0x20 while 3 entries are queued and one is in flight:
  - Queued entries and the in-flight word are never presented.
  - Next request is addr 0x20.
  - Next ir = word[0x20] with ir_pc_1 = 0x21.
- Redirect asserted in the same cycle as a pop and a return, then again the next cycle to 0x40: only the word[0x40] stream appears afterward.
- fetch_pc = 0x3FFF: ir_pc_1 for that instruction = 0x0000_4000, and the next fetch address is 0x0000.
- Random imem_gnt (50%), random ir_ready, random redirects, 10k cycles: a scoreboard confirms no drop, duplication, or reordering within each redirect epoch, and count never exceeds 4.
